// File: rtl/pe_xi_sad.sv
// Motion-estimation PE: preloaded current-block bank, selectable reference pixel,
// registered |curr-ref| (1 cycle) and saturating partial-SAD window (sad_valid 2 cycles after last sample).
module pe_xi_sad #(
  parameter  int PIXEL_W     = 8,
  parameter  int NUM_CB      = 8,
  parameter  int NUM_REF_SRC = 4,
  parameter  int ACC_W       = 16,
  parameter  int ACC_LEN     = 64,
  localparam int CBW         = (NUM_CB      > 1) ? $clog2(NUM_CB)      : 1,
  localparam int RSW         = (NUM_REF_SRC > 1) ? $clog2(NUM_REF_SRC) : 1,
  localparam int CNTW        = (ACC_LEN     > 1) ? $clog2(ACC_LEN)     : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PIXEL_W-1:0]             in_curr,
  input  logic                           in_curr_enable,
  input  logic [CBW-1:0]                 CB_select,
  input  logic [CBW-1:0]                 abs_Control,
  input  logic [NUM_REF_SRC*PIXEL_W-1:0] ref_in,
  input  logic                           change_ref,
  input  logic [RSW-1:0]                 ref_input_Control,
  input  logic                           diff_valid_in,
  input  logic                           acc_clear,
  output logic [PIXEL_W-1:0]             abs_out,
  output logic                           abs_valid,
  output logic [PIXEL_W-1:0]             next_pix,
  output logic [PIXEL_W-1:0]             ref_pix,
  output logic [ACC_W-1:0]               sad_out,
  output logic                           sad_valid
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  logic [PIXEL_W-1:0] r_bank [NUM_CB];
  logic [PIXEL_W-1:0] r_ref;
  logic [PIXEL_W-1:0] r_abs;
  logic               r_abs_vld;
  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNTW-1:0]    r_cnt;
  logic [ACC_W-1:0]   r_sad;
  logic               r_sad_vld;

  logic [PIXEL_W-1:0] w_next;
  logic [PIXEL_W-1:0] w_curr;
  logic [PIXEL_W-1:0] w_ref_sel;
  logic               w_ref_ok;
  logic [PIXEL_W-1:0] w_absdiff;
  logic [ACC_W-1:0]   w_acc_base;
  logic [ACC_W:0]     w_sum;
  logic [ACC_W-1:0]   w_sat;

  // Out-of-range bank/source indices match no entry, so reads give 0 and writes are dropped.
  always_comb begin
    w_next = '0;
    w_curr = '0;
    for (int i = 0; i < NUM_CB; i++) begin
      if (CB_select == CBW'(i))   w_next = r_bank[i];
      if (abs_Control == CBW'(i)) w_curr = r_bank[i];
    end
  end

  always_comb begin
    w_ref_sel = '0;
    w_ref_ok  = 1'b0;
    for (int k = 0; k < NUM_REF_SRC; k++) begin
      if (ref_input_Control == RSW'(k)) begin
        w_ref_sel = ref_in[k*PIXEL_W +: PIXEL_W];
        w_ref_ok  = 1'b1;
      end
    end
  end

  assign w_absdiff  = (w_curr >= r_ref) ? (w_curr - r_ref) : (r_ref - w_curr);
  assign w_acc_base = (r_state == ACCUM) ? r_acc : '0;
  assign w_sum      = {1'b0, w_acc_base} + {{(ACC_W + 1 - PIXEL_W){1'b0}}, r_abs};
  assign w_sat      = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CB; i++) r_bank[i] <= '0;
      r_ref     <= '0;
      r_abs     <= '0;
      r_abs_vld <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CB; i++) begin
        if (in_curr_enable && (CB_select == CBW'(i))) r_bank[i] <= in_curr;
      end
      if (change_ref && w_ref_ok) r_ref <= w_ref_sel;
      if (diff_valid_in)          r_abs <= w_absdiff;
      r_abs_vld <= diff_valid_in;
    end
  end

  // Window accumulator; a clear wins over a sample arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sad     <= '0;
      r_sad_vld <= 1'b0;
    end else begin
      r_sad_vld <= 1'b0;
      if (acc_clear) begin
        r_state <= IDLE;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (r_abs_vld) begin
        if (r_cnt == CNTW'(ACC_LEN - 1)) begin
          r_sad     <= w_sat;
          r_sad_vld <= 1'b1;
          r_state   <= IDLE;
          r_acc     <= '0;
          r_cnt     <= '0;
        end else begin
          r_state <= ACCUM;
          r_acc   <= w_sat;
          r_cnt   <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign abs_out   = r_abs;
  assign abs_valid = r_abs_vld;
  assign next_pix  = w_next;
  assign ref_pix   = r_ref;
  assign sad_out   = r_sad;
  assign sad_valid = r_sad_vld;

endmodule

// File: tb/tb_pe_xi_sad.sv
// Bench for pe_xi_sad: two instances (ACC_W 10 and 9) share stimulus; directed scenarios then random traffic.
module tb_pe_xi_sad;

  localparam int PW   = 8;
  localparam int NCB  = 6;
  localparam int NRS  = 3;
  localparam int ALEN = 4;
  localparam int AWA  = 10;
  localparam int AWB  = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [PW-1:0]   in_curr;
  logic            in_curr_enable;
  logic [2:0]      CB_select;
  logic [2:0]      abs_Control;
  logic [NRS*PW-1:0] ref_in;
  logic            change_ref;
  logic [1:0]      ref_input_Control;
  logic            diff_valid_in;
  logic            acc_clear;

  logic [PW-1:0]   a_abs_out, b_abs_out, a_next_pix, b_next_pix, a_ref_pix, b_ref_pix;
  logic            a_abs_valid, b_abs_valid, a_sad_valid, b_sad_valid;
  logic [AWA-1:0]  a_sad_out;
  logic [AWB-1:0]  b_sad_out;

  always #5 clk = ~clk;

  pe_xi_sad #(.PIXEL_W(PW), .NUM_CB(NCB), .NUM_REF_SRC(NRS), .ACC_W(AWA), .ACC_LEN(ALEN)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_curr(in_curr), .in_curr_enable(in_curr_enable),
    .CB_select(CB_select), .abs_Control(abs_Control), .ref_in(ref_in), .change_ref(change_ref),
    .ref_input_Control(ref_input_Control), .diff_valid_in(diff_valid_in), .acc_clear(acc_clear),
    .abs_out(a_abs_out), .abs_valid(a_abs_valid), .next_pix(a_next_pix), .ref_pix(a_ref_pix),
    .sad_out(a_sad_out), .sad_valid(a_sad_valid));

  pe_xi_sad #(.PIXEL_W(PW), .NUM_CB(NCB), .NUM_REF_SRC(NRS), .ACC_W(AWB), .ACC_LEN(ALEN)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_curr(in_curr), .in_curr_enable(in_curr_enable),
    .CB_select(CB_select), .abs_Control(abs_Control), .ref_in(ref_in), .change_ref(change_ref),
    .ref_input_Control(ref_input_Control), .diff_valid_in(diff_valid_in), .acc_clear(acc_clear),
    .abs_out(b_abs_out), .abs_valid(b_abs_valid), .next_pix(b_next_pix), .ref_pix(b_ref_pix),
    .sad_out(b_sad_out), .sad_valid(b_sad_valid));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pixel values as integers, the open window as a list of samples.
  int m_bank [NCB];
  int m_ref, m_abs, m_absv, m_sad_a, m_sad_b, m_sadv;
  int m_win [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int clamp(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_edge();
    int c, s;
    if (!rst_n) begin
      foreach (m_bank[i]) m_bank[i] = 0;
      m_ref = 0; m_abs = 0; m_absv = 0; m_sad_a = 0; m_sad_b = 0; m_sadv = 0;
      m_win.delete();
      return;
    end
    m_sadv = 0;
    if (acc_clear) begin
      m_win.delete();
    end else if (m_absv != 0) begin
      m_win.push_back(m_abs);
      if (m_win.size() == ALEN) begin
        s = 0;
        foreach (m_win[i]) s += m_win[i];
        m_sad_a = clamp(s, AWA);
        m_sad_b = clamp(s, AWB);
        m_sadv  = 1;
        m_win.delete();
      end
    end
    if (diff_valid_in) begin
      c = (int'(abs_Control) < NCB) ? m_bank[abs_Control] : 0;
      m_abs = (c > m_ref) ? c - m_ref : m_ref - c;
    end
    m_absv = diff_valid_in ? 1 : 0;
    if (in_curr_enable && int'(CB_select) < NCB) m_bank[CB_select] = int'(in_curr);
    if (change_ref && int'(ref_input_Control) < NRS)
      m_ref = int'(ref_in[ref_input_Control*PW +: PW]);
  endtask

  task automatic step();
    int np;
    @(posedge clk);
    model_edge();
    #1;
    np = (int'(CB_select) < NCB) ? m_bank[CB_select] : 0;
    check("abs_out",   a_abs_out,   m_abs);
    check("abs_valid", a_abs_valid, m_absv);
    check("b_abs_out", b_abs_out,   m_abs);
    check("ref_pix",   a_ref_pix,   m_ref);
    check("next_pix",  a_next_pix,  np);
    check("sad_a",     a_sad_out,   m_sad_a);
    check("sad_b",     b_sad_out,   m_sad_b);
    check("sadv_a",    a_sad_valid, m_sadv);
    check("sadv_b",    b_sad_valid, m_sadv);
  endtask

  task automatic idle();
    rst_n = 1'b1; in_curr_enable = 1'b0; change_ref = 1'b0;
    diff_valid_in = 1'b0; acc_clear = 1'b0;
  endtask

  task automatic load(input int idx, input int val);
    idle(); CB_select = 3'(idx); in_curr = 8'(val); in_curr_enable = 1'b1;
    step(); idle();
  endtask

  task automatic samples(input int idx, input int n);
    idle(); abs_Control = 3'(idx); diff_valid_in = 1'b1;
    for (int i = 0; i < n; i++) step();
    idle();
  endtask

  task automatic clear_win();
    idle(); acc_clear = 1'b1; step(); idle();
  endtask

  initial begin
    idle(); rst_n = 1'b0; in_curr = '0; CB_select = '0; abs_Control = '0;
    ref_in = '0; ref_input_Control = '0;
    step(); step();
    check("rst_abs_valid", a_abs_valid, 0);
    check("rst_sad", b_sad_out, 0);
    idle();

    // Preload and difference
    CB_select = 3; in_curr = 200; in_curr_enable = 1'b1;
    ref_in = '0; ref_in[2*PW +: PW] = 50; ref_input_Control = 2; change_ref = 1'b1;
    step(); idle();
    samples(3, 1);
    check("tp_abs150", a_abs_out, 150);
    check("tp_absv", a_abs_valid, 1);
    check("tp_next200", a_next_pix, 200);
    clear_win();

    // Window of four 150s; then a 5th sample opens the next window
    samples(3, 4);
    step();
    check("win_sadv", a_sad_valid, 1);
    check("win_sad600", a_sad_out, 600);
    check("win_sat511", b_sad_out, 511);
    step();
    check("win_pulse1", a_sad_valid, 0);
    samples(3, 1); step();
    samples(3, 3); step();
    check("win2_sad600", a_sad_out, 600);
    check("win2_sadv", a_sad_valid, 1);

    // Reverse sign, out-of-range reference index
    CB_select = 0; in_curr = 10; in_curr_enable = 1'b1;
    ref_in = '0; ref_in[1*PW +: PW] = 250; ref_input_Control = 1; change_ref = 1'b1;
    step(); idle();
    ref_in = {3{8'd77}}; ref_input_Control = 3; change_ref = 1'b1;
    abs_Control = 0; diff_valid_in = 1'b1;
    step(); idle();
    check("rev_abs240", a_abs_out, 240);
    check("ref_hold250", a_ref_pix, 250);

    // Out-of-range bank write
    load(7, 99);
    check("oob_next0", a_next_pix, 0);

    // Saturation: 255,255,10,10
    clear_win();
    CB_select = 1; in_curr = 255; in_curr_enable = 1'b1;
    ref_in = '0; ref_input_Control = 0; change_ref = 1'b1;
    step(); idle();
    load(2, 10);
    samples(1, 2); samples(2, 2); step();
    check("sat_b511", b_sad_out, 511);
    check("sat_a530", a_sad_out, 530);

    // Clear collides with the third sample
    load(4, 1);
    clear_win();
    samples(4, 3);
    acc_clear = 1'b1; step(); idle();
    check("clr_nosadv", a_sad_valid, 0);
    samples(4, 4); step();
    check("clr_sad4", a_sad_out, 4);

    // Reset mid-window
    load(5, 20);
    clear_win();
    samples(5, 2);
    rst_n = 1'b0; step(); idle();
    check("mrst_abs", a_abs_out, 0);
    check("mrst_sad", a_sad_out, 0);
    check("mrst_ref", a_ref_pix, 0);
    load(5, 20);
    samples(5, 4); step();
    check("mrst_sad80", a_sad_out, 80);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      rst_n             = ($urandom_range(0, 149) != 0);
      acc_clear         = ($urandom_range(0, 39) == 0);
      diff_valid_in     = ($urandom_range(0, 3) != 0);
      in_curr_enable    = ($urandom_range(0, 2) == 0);
      change_ref        = ($urandom_range(0, 3) == 0);
      in_curr           = 8'($urandom);
      ref_in            = 24'($urandom);
      CB_select         = 3'($urandom_range(0, 7));
      abs_Control       = 3'($urandom_range(0, 7));
      ref_input_Control = 2'($urandom_range(0, 3));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pe_xi_sad.md
Name: pe_xi_sad

Overview:
Parametrised next-generation processing element for the HEVC integer motion-estimation array. It holds NUM_CB preloaded current-block pixels and one reference pixel taken from NUM_REF_SRC neighbouring PEs. It produces a registered absolute difference with a valid flag. It also accumulates a per-PE partial SAD over ACC_LEN valid samples, with saturation and a completion pulse.

Parameters:
PIXEL_W, 8, pixel bit width
NUM_CB, 8, number of current-block pixel registers (>=2)
NUM_REF_SRC, 4, number of reference input sources (>=2)
ACC_W, 16, partial-SAD accumulator width (>=PIXEL_W)
ACC_LEN, 64, valid samples per SAD window (>=1)
Derived: CBW=max(1,clog2(NUM_CB)), RSW=max(1,clog2(NUM_REF_SRC)), CNTW=max(1,clog2(ACC_LEN))

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_curr  in  PIXEL_W  current-frame pixel to preload
in_curr_enable  in  1  write in_curr into bank[CB_select]
CB_select  in  CBW  preload/forward bank index
abs_Control  in  CBW  bank index used for difference
ref_in  in  NUM_REF_SRC*PIXEL_W  packed reference sources, source k at bits [k*PIXEL_W +: PIXEL_W]
change_ref  in  1  load ref_pix from selected source
ref_input_Control  in  RSW  reference source index
diff_valid_in  in  1  compute a difference this cycle
acc_clear  in  1  abort/clear current SAD window
abs_out  out  PIXEL_W  registered |curr-ref|
abs_valid  out  1  abs_out valid
next_pix  out  PIXEL_W  bank[CB_select] forwarded to next PE (combinational)
ref_pix  out  PIXEL_W  reference pixel register, forwarded to neighbours
sad_out  out  ACC_W  last completed window SAD
sad_valid  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low, sampled on the rising edge of clk only.
- Reset values: all bank registers, ref_pix, abs_out, abs_valid, accumulator, counter, sad_out and sad_valid are 0. Reset mid-window discards all partial state.
- Bank write: when in_curr_enable=1, bank[CB_select] is written with in_curr on the clock edge. If CB_select>=NUM_CB, nothing is written.
- next_pix: equals bank[CB_select]; it is 0 when CB_select>=NUM_CB. Zero latency.
- ref_pix: when change_ref=1, it loads slice ref_input_Control of ref_in. It holds if the index is >=NUM_REF_SRC or change_ref=0.
- Difference stage, latency 1:
  - When diff_valid_in=1, abs_out <= |C-R|, where C=bank[abs_Control] (0 if the index is out of range) and R is the pre-edge ref_pix value.
  - abs_valid <= diff_valid_in every cycle. abs_out holds when diff_valid_in=0.
  - Simultaneous bank write or change_ref in the same cycle affects only later samples.
- Accumulator FSM, states IDLE (cnt=0, acc=0) and ACCUM:
  - Priority: rst_n low > acc_clear > abs_valid.
  - acc_clear=1: acc<=0, cnt<=0, go to IDLE. A concurrent abs_valid sample is discarded, and sad_valid stays 0.
  - abs_valid=1 and cnt<ACC_LEN-1: acc<=sat(acc+abs_out), cnt<=cnt+1, state is ACCUM.
  - abs_valid=1 and cnt==ACC_LEN-1: sad_out<=sat(acc+abs_out), sad_valid<=1, acc<=0, cnt<=0, go to IDLE. With ACC_LEN=1, every valid sample completes a window.
  - sat(x) clamps to 2^ACC_W-1. The sum is computed ACC_W+1 bits wide. abs_out is zero-extended.
  - sad_valid is high for exactly one cycle per completion. sad_out holds until the next completion and is not cleared by acc_clear.
- Pipeline: diff_valid_in to sad_valid is 2 cycles for the last sample of a window. Back-to-back windows need no idle cycles.

Test Plan:
- Preload and difference: write bank[3]=200; ref_in source 2=50, ref_input_Control=2, change_ref=1; next cycle abs_Control=3, diff_valid_in=1 -> one cycle later abs_out=150, abs_valid=1; next_pix with CB_select=3 reads 200.
- Reverse sign and hold: bank[0]=10, ref_pix=250 -> abs_out=240. change_ref=1 with ref_input_Control=3 while NUM_REF_SRC=3 -> ref_pix stays 250.
- SAD window: ACC_LEN=4, four consecutive valid samples of 150 -> sad_out=600 and sad_valid high for 1 cycle, 2 cycles after the 4th diff_valid_in; a 5th sample of 150 -> acc=150, cnt=1.
- Saturation: ACC_W=9, ACC_LEN=4, samples 255,255,10,10 -> sad_out=511.
- Clear and range checks:
  - acc_clear asserted together with the 3rd valid sample of a 4-sample window -> no sad_valid; the next 4 samples of 1 give sad_out=4.
  - NUM_CB=6, CB_select=7 with in_curr_enable=1 -> no bank changes; next_pix=0.
- Reset mid-operation: rst_n=0 for 1 cycle after 2 of 4 samples -> all outputs 0 on the next cycle; a following full window of 4x20 -> sad_out=80.
